// File: rtl/sc_regbank_pkg.sv
// Shared widths, reset constants and fixed-entry helper for the sc_regbank slice.
package sc_regbank_pkg;

  localparam int unsigned DATAWIDTH_BUS_DEF = 32;
  localparam int unsigned ADDRWIDTH_DEF     = 4;
  localparam int unsigned FIXED_ENTRIES     = 2;

  localparam logic [31:0] REG_FIXED0_INIT_DEF = 32'h0000_0000;
  localparam logic [31:0] REG_FIXED1_INIT_DEF = 32'h0000_0001;

  // Entries below FIXED_ENTRIES hold the absorbed constants and never accept writes.
  function automatic logic is_fixed(input logic [31:0] addr);
    return (addr < FIXED_ENTRIES);
  endfunction

endpackage

// File: rtl/sc_regbank_if.sv
// Write/read bus of the register bank; master drives requests, slave returns data and flags.
interface sc_regbank_if
  import sc_regbank_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
  parameter int unsigned ADDRWIDTH     = ADDRWIDTH_DEF
);

  logic                     SC_RegBANK_wr_En_InHigh;
  logic [ADDRWIDTH-1:0]     SC_RegBANK_wr_Addr_InBus;
  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_wr_data_InBus;
  logic                     SC_RegBANK_rd_En_InHigh;
  logic [ADDRWIDTH-1:0]     SC_RegBANK_rdA_Addr_InBus;
  logic [ADDRWIDTH-1:0]     SC_RegBANK_rdB_Addr_InBus;
  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_dataA_OutBus;
  logic [DATAWIDTH_BUS-1:0] SC_RegBANK_dataB_OutBus;
  logic                     SC_RegBANK_rd_Valid_OutHigh;
  logic                     SC_RegBANK_wr_Err_OutHigh;

  modport master (
    output SC_RegBANK_wr_En_InHigh, SC_RegBANK_wr_Addr_InBus, SC_RegBANK_wr_data_InBus,
    output SC_RegBANK_rd_En_InHigh, SC_RegBANK_rdA_Addr_InBus, SC_RegBANK_rdB_Addr_InBus,
    input  SC_RegBANK_dataA_OutBus, SC_RegBANK_dataB_OutBus,
    input  SC_RegBANK_rd_Valid_OutHigh, SC_RegBANK_wr_Err_OutHigh
  );

  modport slave (
    input  SC_RegBANK_wr_En_InHigh, SC_RegBANK_wr_Addr_InBus, SC_RegBANK_wr_data_InBus,
    input  SC_RegBANK_rd_En_InHigh, SC_RegBANK_rdA_Addr_InBus, SC_RegBANK_rdB_Addr_InBus,
    output SC_RegBANK_dataA_OutBus, SC_RegBANK_dataB_OutBus,
    output SC_RegBANK_rd_Valid_OutHigh, SC_RegBANK_wr_Err_OutHigh
  );

endinterface

// File: rtl/sc_regbank_rdport.sv
// One registered read port of the bank. Write-through bypass when SC_REGBANK_BYPASS_EN is defined.
module sc_regbank_rdport
  import sc_regbank_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
  parameter int unsigned ADDRWIDTH     = ADDRWIDTH_DEF,
  parameter int unsigned NUM_ENTRIES   = 2**ADDRWIDTH_DEF
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    rd_en_i,
  input  logic [ADDRWIDTH-1:0]                    rd_addr_i,
  input  logic [NUM_ENTRIES-1:0][DATAWIDTH_BUS-1:0] entries_i,
  input  logic                                    wr_en_i,
  input  logic [ADDRWIDTH-1:0]                    wr_addr_i,
  input  logic [DATAWIDTH_BUS-1:0]                wr_data_i,
  output logic [DATAWIDTH_BUS-1:0]                data_o
);

  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic [DATAWIDTH_BUS-1:0] rd_word;

`ifdef SC_REGBANK_BYPASS_EN
  logic bypass_hit;

  // Fixed addresses never bypass, so a read racing an illegal write still sees the constant.
  always_comb begin
    bypass_hit = wr_en_i && !is_fixed(32'(wr_addr_i)) && (wr_addr_i == rd_addr_i);
    rd_word    = bypass_hit ? wr_data_i : entries_i[rd_addr_i];
  end
`else
  logic unused_wr_side;

  always_comb begin
    unused_wr_side = ^{wr_en_i, wr_addr_i, wr_data_i};
    rd_word        = entries_i[rd_addr_i];
  end
`endif

  always_comb begin
    data_d = data_q;
    if (rd_en_i) data_d = rd_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/sc_regbank.sv
// General-purpose register bank: entries 0/1 are read-only constants, two registered read ports.
// Optional write-through bypass selected by SC_REGBANK_BYPASS_EN (see sc_regbank_rdport).
module sc_regbank
  import sc_regbank_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS   = DATAWIDTH_BUS_DEF,
  parameter int unsigned ADDRWIDTH       = ADDRWIDTH_DEF,
  parameter logic [DATAWIDTH_BUS-1:0] REG_FIXED0_INIT = DATAWIDTH_BUS'(REG_FIXED0_INIT_DEF),
  parameter logic [DATAWIDTH_BUS-1:0] REG_FIXED1_INIT = DATAWIDTH_BUS'(REG_FIXED1_INIT_DEF)
) (
  input  logic SC_RegBANK_CLOCK_50,
  input  logic SC_RegBANK_RESET_InLow,
  sc_regbank_if.slave bus
);

  localparam int unsigned NUM_ENTRIES = 2**ADDRWIDTH;

  logic [NUM_ENTRIES-1:0][DATAWIDTH_BUS-1:0] mem_q, mem_d;
  logic wr_err_q, wr_err_d;
  logic rd_valid_q, rd_valid_d;
  logic wr_to_fixed;

  always_comb begin
    wr_to_fixed = is_fixed(32'(bus.SC_RegBANK_wr_Addr_InBus));
    mem_d       = mem_q;
    wr_err_d    = wr_err_q;
    rd_valid_d  = bus.SC_RegBANK_rd_En_InHigh;
    if (bus.SC_RegBANK_wr_En_InHigh) begin
      if (wr_to_fixed) wr_err_d = 1'b1;
      else             mem_d[bus.SC_RegBANK_wr_Addr_InBus] = bus.SC_RegBANK_wr_data_InBus;
    end
  end

  // Fixed entries are loaded only by reset and never see mem_d updates.
  always_ff @(posedge SC_RegBANK_CLOCK_50 or negedge SC_RegBANK_RESET_InLow) begin
    if (!SC_RegBANK_RESET_InLow) begin
      mem_q      <= '0;
      mem_q[0]   <= REG_FIXED0_INIT;
      mem_q[1]   <= REG_FIXED1_INIT;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_err_q   <= wr_err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  sc_regbank_rdport #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS),
    .ADDRWIDTH    (ADDRWIDTH),
    .NUM_ENTRIES  (NUM_ENTRIES)
  ) u_rdport_a (
    .clk_i    (SC_RegBANK_CLOCK_50),
    .rst_ni   (SC_RegBANK_RESET_InLow),
    .rd_en_i  (bus.SC_RegBANK_rd_En_InHigh),
    .rd_addr_i(bus.SC_RegBANK_rdA_Addr_InBus),
    .entries_i(mem_q),
    .wr_en_i  (bus.SC_RegBANK_wr_En_InHigh),
    .wr_addr_i(bus.SC_RegBANK_wr_Addr_InBus),
    .wr_data_i(bus.SC_RegBANK_wr_data_InBus),
    .data_o   (bus.SC_RegBANK_dataA_OutBus)
  );

  sc_regbank_rdport #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS),
    .ADDRWIDTH    (ADDRWIDTH),
    .NUM_ENTRIES  (NUM_ENTRIES)
  ) u_rdport_b (
    .clk_i    (SC_RegBANK_CLOCK_50),
    .rst_ni   (SC_RegBANK_RESET_InLow),
    .rd_en_i  (bus.SC_RegBANK_rd_En_InHigh),
    .rd_addr_i(bus.SC_RegBANK_rdB_Addr_InBus),
    .entries_i(mem_q),
    .wr_en_i  (bus.SC_RegBANK_wr_En_InHigh),
    .wr_addr_i(bus.SC_RegBANK_wr_Addr_InBus),
    .wr_data_i(bus.SC_RegBANK_wr_data_InBus),
    .data_o   (bus.SC_RegBANK_dataB_OutBus)
  );

  assign bus.SC_RegBANK_rd_Valid_OutHigh = rd_valid_q;
  assign bus.SC_RegBANK_wr_Err_OutHigh   = wr_err_q;

endmodule

// File: tb/tb_sc_regbank.sv
// Scoreboard bench for sc_regbank: driver queues expected read data, negedge monitor checks it.
module tb_sc_regbank;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic exp_v;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t sb[$];

`ifdef SC_REGBANK_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  sc_regbank_if #(.DATAWIDTH_BUS(32), .ADDRWIDTH(4)) bus ();

  sc_regbank #(
    .DATAWIDTH_BUS  (32),
    .ADDRWIDTH      (4),
    .REG_FIXED0_INIT(32'h0000_0000),
    .REG_FIXED1_INIT(32'h0000_0001)
  ) dut (
    .SC_RegBANK_CLOCK_50   (clk),
    .SC_RegBANK_RESET_InLow(rst_n),
    .bus                   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic re, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    bus.SC_RegBANK_wr_En_InHigh   = we;
    bus.SC_RegBANK_wr_Addr_InBus  = wa;
    bus.SC_RegBANK_wr_data_InBus  = wd;
    bus.SC_RegBANK_rd_En_InHigh   = re;
    bus.SC_RegBANK_rdA_Addr_InBus = ra;
    bus.SC_RegBANK_rdB_Addr_InBus = rb;
    if (re) begin
      e.a = ea;
      e.b = eb;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.SC_RegBANK_wr_En_InHigh = 1'b0;
    bus.SC_RegBANK_rd_En_InHigh = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dataA"}, bus.SC_RegBANK_dataA_OutBus, 32'h0);
    chk({tag, "_dataB"}, bus.SC_RegBANK_dataB_OutBus, 32'h0);
    chk({tag, "_valid"}, {31'h0, bus.SC_RegBANK_rd_Valid_OutHigh}, 32'h0);
    chk({tag, "_wr_err"}, {31'h0, bus.SC_RegBANK_wr_Err_OutHigh}, 32'h0);
  endtask

  // Reference for rd_Valid: one-cycle delayed rd_En, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_v <= 1'b0;
    else        exp_v <= bus.SC_RegBANK_rd_En_InHigh;
  end

  always @(negedge clk) begin
    exp_t e;
    chk("rd_valid", {31'h0, bus.SC_RegBANK_rd_Valid_OutHigh}, {31'h0, exp_v});
    if (bus.SC_RegBANK_rd_Valid_OutHigh === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 (scoreboard empty)");
      end else begin
        e = sb.pop_front();
        chk("rdA", bus.SC_RegBANK_dataA_OutBus, e.a);
        chk("rdB", bus.SC_RegBANK_dataB_OutBus, e.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sweep_a [4];
    logic [31:0] sweep_b [4];
    sweep_a = '{32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    sweep_b = '{32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'hCCCC_CCCC};
    checks = 0;
    errors = 0;
    bus.SC_RegBANK_wr_En_InHigh   = 1'b0;
    bus.SC_RegBANK_wr_Addr_InBus  = '0;
    bus.SC_RegBANK_wr_data_InBus  = '0;
    bus.SC_RegBANK_rd_En_InHigh   = 1'b0;
    bus.SC_RegBANK_rdA_Addr_InBus = '0;
    bus.SC_RegBANK_rdB_Addr_InBus = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constants visible on both ports, single-cycle valid.
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd1, 32'h0000_0000, 32'h0000_0001);
    idle();
    idle();

    // Plain write then read.
    step(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd2, 32'hDEAD_BEEF, 32'h0000_0000);
    idle();
    idle();
    chk("hold_dataA", bus.SC_RegBANK_dataA_OutBus, 32'hDEAD_BEEF);
    chk("wr_err_clean", {31'h0, bus.SC_RegBANK_wr_Err_OutHigh}, 32'h0);

    // Illegal write to fixed entry 1, with a coinciding read of it.
    step(1'b1, 4'd1, 32'h1234_5678, 1'b1, 4'd1, 4'd0, 32'h0000_0001, 32'h0000_0000);
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 4'd1, 32'h0000_0001, 32'h0000_0001);
    chk("wr_err_set", {31'h0, bus.SC_RegBANK_wr_Err_OutHigh}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("wr_err_sticky", {31'h0, bus.SC_RegBANK_wr_Err_OutHigh}, 32'h1);
    end

    // Same-cycle write/read on port A, then on port B.
    step(1'b1, 4'd7, 32'hCAFE_F00D, 1'b1, 4'd7, 4'd5,
         BYP ? 32'hCAFE_F00D : 32'h0, 32'hDEAD_BEEF);
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);
    step(1'b1, 4'd8, 32'hA5A5_A5A5, 1'b1, 4'd2, 4'd8,
         32'h0, BYP ? 32'hA5A5_A5A5 : 32'h0);
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd8, 4'd2, 32'hA5A5_A5A5, 32'h0);
    idle();

    // Fill 2..15 with addr*0x11111111, then a 4-cycle back-to-back sweep.
    for (int unsigned a = 2; a < 16; a++)
      step(1'b1, 4'(a), a * 32'h1111_1111, 1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'd0, 32'h0, 1'b1, 4'(i + 2), 4'(15 - i), sweep_a[i], sweep_b[i]);
    idle();

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      step(1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 4'(15 - i),
           (i == 1) ? 32'h0000_0001 : 32'h0000_0000, 32'h0000_0000);
    idle();
    idle();

    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
